// File: rtl/rt_ibex_pcs_pkg.sv
// rt_ibex_pcs_pkg: FSM state type and default parameters
// shared by the PCS sequencer and its level stack.
package rt_ibex_pcs_pkg;

  localparam int unsigned NrSavedRegsDef   = 9;
  localparam int unsigned MaxDepthDef      = 8;
  localparam int unsigned IrqLevelWidthDef = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PUSH    = 2'd1,
    ST_RESTORE = 2'd2
  } pcs_state_e;

endpackage

// File: rtl/rt_ibex_pcs_level_stack.sv
// rt_ibex_pcs_level_stack: LIFO of interrupt levels, Depth x Width.
// Ports: clk_i, rst_ni, i_push, i_pop, i_data, o_top (0 when empty), o_count.
module rt_ibex_pcs_level_stack
  import rt_ibex_pcs_pkg::*;
#(
  parameter int unsigned Depth = MaxDepthDef,
  parameter int unsigned Width = IrqLevelWidthDef
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [Width-1:0]           i_data,
  output logic [Width-1:0]           o_top,
  output logic [$clog2(Depth+1)-1:0] o_count
);

  localparam int unsigned CW = $clog2(Depth + 1);
  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CW-1:0] Full = CW'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_cnt_m1;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_top_idx;

  assign w_cnt_m1  = r_count - CW'(1);
  assign w_wr_idx  = r_count[AW-1:0];
  assign w_top_idx = w_cnt_m1[AW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push && (r_count != Full)) begin
      r_mem[w_wr_idx] <= i_data;
      r_count         <= r_count + CW'(1);
    end else if (i_pop && (r_count != '0)) begin
      r_mem[w_top_idx] <= '0;
      r_count          <= w_cnt_m1;
    end
  end

  assign o_top   = (r_count == '0) ? '0 : r_mem[w_top_idx];
  assign o_count = r_count;

endmodule

// File: rtl/rt_ibex_pcs_seq.sv
// rt_ibex_pcs_seq: nested-interrupt context push / register restore
// sequencer. Optional macro RT_IBEX_PCS_LEVEL_CHECK_EN enables level check.
// Ports: irq_ack_i/irq_level_i, mret_req_i in; lifo/rf strobes, stall_o,
// mret_done_o, depth_o, curr_level_o, irq_allow_o, error flags out.
module rt_ibex_pcs_seq
  import rt_ibex_pcs_pkg::*;
#(
  parameter int unsigned NrSavedRegs   = NrSavedRegsDef,
  parameter int unsigned MaxDepth      = MaxDepthDef,
  parameter int unsigned IrqLevelWidth = IrqLevelWidthDef
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          irq_ack_i,
  input  logic [IrqLevelWidth-1:0]      irq_level_i,
  input  logic                          mret_req_i,
  output logic                          lifo_push_o,
  output logic                          lifo_pop_o,
  output logic                          rf_we_o,
  output logic [$clog2(NrSavedRegs)-1:0] rf_idx_o,
  output logic                          stall_o,
  output logic                          mret_done_o,
  output logic [$clog2(MaxDepth+1)-1:0] depth_o,
  output logic [IrqLevelWidth-1:0]      curr_level_o,
  output logic                          irq_allow_o,
  output logic                          overflow_o,
  output logic                          underflow_o,
  output logic                          level_err_o
);

  localparam int unsigned IdxW = $clog2(NrSavedRegs);
  localparam int unsigned DW   = $clog2(MaxDepth + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NrSavedRegs - 1);
  localparam logic [DW-1:0]   MaxD    = DW'(MaxDepth);

  pcs_state_e               r_state;
  logic [IdxW-1:0]          r_idx;
  logic [IrqLevelWidth-1:0] r_level;
  logic                     r_ovf;

  logic [DW-1:0]            w_depth;
  logic [IrqLevelWidth-1:0] w_top;
  logic w_idle, w_full, w_empty, w_lvl_bad;
  logic w_ack, w_take, w_mret, w_start;
  logic w_underflow, w_push, w_last;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_full  = (w_depth == MaxD);
  assign w_empty = (w_depth == '0);

`ifdef RT_IBEX_PCS_LEVEL_CHECK_EN
  assign w_lvl_bad = !w_empty && (irq_level_i <= w_top);
`else
  assign w_lvl_bad = 1'b0;
`endif

  // Ack has priority; a concurrent mret stays pending.
  assign w_ack       = w_idle && irq_ack_i;
  assign w_take      = w_ack && !w_full && !w_lvl_bad;
  assign w_mret      = w_idle && mret_req_i && !irq_ack_i;
  assign w_start     = w_mret && !w_empty;
  assign w_underflow = w_mret && w_empty;
  assign w_push      = (r_state == ST_PUSH);
  assign w_last      = (r_state == ST_RESTORE) && (r_idx == LastIdx);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_level <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_state <= ST_PUSH;
            r_level <= irq_level_i;
          end else if (w_start) begin
            r_state <= ST_RESTORE;
            r_idx   <= '0;
          end
        end
        ST_PUSH: r_state <= ST_IDLE;
        ST_RESTORE: begin
          if (w_last) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + IdxW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovf <= 1'b0;
    end else if (w_ack && w_full) begin
      r_ovf <= 1'b1;
    end
  end

  // Level enters the stack at the end of PUSH, together with depth.
  rt_ibex_pcs_level_stack #(
    .Depth (MaxDepth),
    .Width (IrqLevelWidth)
  ) u_lvl (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_push),
    .i_pop   (w_last),
    .i_data  (r_level),
    .o_top   (w_top),
    .o_count (w_depth)
  );

  assign lifo_push_o  = w_push;
  assign lifo_pop_o   = w_last;
  assign rf_we_o      = (r_state == ST_RESTORE);
  assign rf_idx_o     = r_idx;
  assign stall_o      = !w_idle;
  assign mret_done_o  = w_last || w_underflow;
  assign depth_o      = w_depth;
  assign curr_level_o = w_top;
  assign irq_allow_o  = w_idle && (w_depth < MaxD);
  assign overflow_o   = r_ovf;
  assign underflow_o  = w_underflow;
  assign level_err_o  = w_ack && !w_full && w_lvl_bad;

endmodule

// File: tb/tb_rt_ibex_pcs_seq.sv
// tb_rt_ibex_pcs_seq: directed scoreboard bench for rt_ibex_pcs_seq.
// Stimulus queues expected strobe events; a negedge monitor compares them.
module tb_rt_ibex_pcs_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ack;
  logic [7:0] lvl;
  logic       mret;
  logic       push_o, pop_o, we_o, stall_o, done_o;
  logic [3:0] idx_o;
  logic [3:0] depth_o;
  logic [7:0] curr_o;
  logic       allow_o, ovf_o, uf_o, lerr_o;

  always #5 clk = ~clk;

  rt_ibex_pcs_seq dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .irq_ack_i    (ack),
    .irq_level_i  (lvl),
    .mret_req_i   (mret),
    .lifo_push_o  (push_o),
    .lifo_pop_o   (pop_o),
    .rf_we_o      (we_o),
    .rf_idx_o     (idx_o),
    .stall_o      (stall_o),
    .mret_done_o  (done_o),
    .depth_o      (depth_o),
    .curr_level_o (curr_o),
    .irq_allow_o  (allow_o),
    .overflow_o   (ovf_o),
    .underflow_o  (uf_o),
    .level_err_o  (lerr_o)
  );

  typedef struct packed {
    logic       push;
    logic       pop;
    logic       we;
    logic [3:0] idx;
    logic       done;
    logic       uf;
    logic       lerr;
    logic       stall;
  } ev_t;

  ev_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  function automatic ev_t ev(bit p, bit o, bit w, logic [3:0] i,
                             bit d, bit u, bit l, bit s);
    ev_t e;
    e = '{push: p, pop: o, we: w, idx: i, done: d,
          uf: u, lerr: l, stall: s};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  ev_t m_act, m_exp;
  always @(negedge clk) begin
    m_act = ev(push_o, pop_o, we_o, idx_o, done_o, uf_o, lerr_o, stall_o);
    if (push_o | pop_o | we_o | done_o | uf_o | lerr_o) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event act=%h req=none", m_act);
      end else begin
        m_exp = exp_q.pop_front();
        if (m_act !== m_exp) begin
          miscompares++;
          $display("FAIL event act=%h req=%h", m_act, m_exp);
        end
      end
    end
  end

  task automatic do_ack(input logic [7:0] l, input bit e_push,
                        input bit e_lerr);
    if (e_lerr) exp_q.push_back(ev(0, 0, 0, 4'd0, 0, 0, 1, 0));
    if (e_push) exp_q.push_back(ev(1, 0, 0, 4'd0, 0, 0, 0, 1));
    ack = 1'b1;
    lvl = l;
    @(posedge clk); #1;
    ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic exp_restore();
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(ev(0, i == 8, 1, 4'(i), i == 8, 0, 0, 1));
    end
  endtask

  task automatic wait_done(input string nm, input int lat);
    int n;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_o) break;
      n++;
    end
    chk(nm, n, lat);
    @(posedge clk); #1;
    mret = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ack   = 1'b0;
    lvl   = 8'd0;
    mret  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_depth", depth_o, 0);
    chk("rst_level", curr_o, 0);
    chk("rst_allow", allow_o, 1);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_idx", idx_o, 0);
    chk("rst_we", we_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_ack(8'd5, 1, 0);
    chk("ack5_depth", depth_o, 1);
    chk("ack5_level", curr_o, 5);
    chk("ack5_allow", allow_o, 1);

    exp_restore();
    mret = 1'b1;
    wait_done("mret_lat", 9);
    chk("mret_depth", depth_o, 0);
    chk("mret_level", curr_o, 0);

    exp_q.push_back(ev(0, 0, 0, 4'd0, 1, 1, 0, 0));
    mret = 1'b1;
    wait_done("uf_lat", 0);
    chk("uf_depth", depth_o, 0);

    do_ack(8'd3, 1, 0);
    do_ack(8'd4, 1, 0);
    chk("d2_depth", depth_o, 2);
    exp_q.push_back(ev(1, 0, 0, 4'd0, 0, 0, 0, 1));
    exp_restore();
    ack  = 1'b1;
    lvl  = 8'd6;
    mret = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    @(posedge clk); #1;
    chk("both_depth3", depth_o, 3);
    chk("both_level6", curr_o, 6);
    wait_done("both_lat", 9);
    chk("both_depth2", depth_o, 2);
    chk("both_level4", curr_o, 4);

    do_reset();
    for (int i = 1; i <= 8; i++) do_ack(8'(i), 1, 0);
    chk("full_allow_pre", allow_o, 0);
    do_ack(8'd9, 0, 0);
    chk("full_depth", depth_o, 8);
    chk("full_allow", allow_o, 0);
    chk("full_ovf", ovf_o, 1);
    chk("full_level", curr_o, 8);
    do_reset();
    chk("ovf_cleared", ovf_o, 0);

    do_ack(8'd5, 1, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ev(0, 0, 1, 4'(i), 0, 0, 0, 1));
    end
    mret = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    mret  = 1'b0;
    #1;
    chk("abort_we", we_o, 0);
    chk("abort_depth", depth_o, 0);
    chk("abort_idx", idx_o, 0);
    chk("abort_stall", stall_o, 0);
    chk("abort_allow", allow_o, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_resume_we", we_o, 0);
    chk("no_resume_stall", stall_o, 0);

    do_ack(8'd5, 1, 0);
`ifdef RT_IBEX_PCS_LEVEL_CHECK_EN
    do_ack(8'd3, 0, 1);
    chk("lchk_depth", depth_o, 1);
    chk("lchk_level", curr_o, 5);
`else
    do_ack(8'd3, 1, 0);
    chk("lchk_depth", depth_o, 2);
    chk("lchk_level", curr_o, 3);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
